// File: rtl/ctrl_pkg.sv
// Shared RV32 decode definitions: opcode/funct constants, write-back select
// encoding and the control bundle carried from decode to execute.
package ctrl_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SR  = 3'b101;

   typedef enum logic [1:0] {
      WB_PC4 = 2'b00,
      WB_ALU = 2'b01,
      WB_MEM = 2'b10,
      WB_IMM = 2'b11
   } wb_sel_e;

   typedef struct packed {
      logic       rs1_en;
      logic       rs2_en;
      logic       brOrJmp;
      wb_sel_e    wbSel;
      logic       brUsed;
      logic       br_useJalr;
      logic       is_branch;
      logic [2:0] func3;
      logic       func1;
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic [2:0] funcMem;
      logic       is_mul;
      logic       illegal;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } ctrl_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Purely combinational RV32I instruction decoder producing the control bundle;
// funct7=0000001 R-type is accepted as a multiply/divide only when EN_MEXT is set.
module rv_ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit EN_MEXT = 1'b0
) (
   input  logic [31:0] instr_i,
   output ctrl_t       ctrl_o
);

   ctrl_t      dec;
   logic [6:0] funct7;
   logic [2:0] funct3;

   assign funct7 = instr_i[31:25];
   assign funct3 = instr_i[14:12];

   always_comb begin
      dec     = '0;
      dec.rd  = instr_i[11:7];
      dec.rs1 = instr_i[19:15];
      dec.rs2 = instr_i[24:20];
      case (instr_i[6:0])
         OP_LUI: begin
            dec.wbSel    = WB_IMM;
            dec.regWrite = 1'b1;
         end
         OP_AUIPC: begin
            dec.wbSel    = WB_ALU;
            dec.func3    = F3_ADD;
            dec.regWrite = 1'b1;
         end
         OP_JAL: begin
            dec.brOrJmp  = 1'b1;
            dec.wbSel    = WB_PC4;
            dec.regWrite = 1'b1;
         end
         OP_JALR: begin
            dec.rs1_en     = 1'b1;
            dec.brUsed     = 1'b1;
            dec.br_useJalr = 1'b1;
            dec.func3      = F3_ADD;
            dec.wbSel      = WB_PC4;
            dec.regWrite   = 1'b1;
         end
         OP_BRANCH: begin
            dec.rs1_en    = 1'b1;
            dec.rs2_en    = 1'b1;
            dec.is_branch = 1'b1;
            dec.func3     = funct3;
         end
         OP_STORE: begin
            dec.rs1_en   = 1'b1;
            dec.rs2_en   = 1'b1;
            dec.memWrite = 1'b1;
            dec.func3    = F3_ADD;
            dec.funcMem  = funct3;
         end
         OP_LOAD: begin
            dec.rs1_en   = 1'b1;
            dec.memRead  = 1'b1;
            dec.wbSel    = WB_MEM;
            dec.regWrite = 1'b1;
            dec.func3    = F3_ADD;
            dec.funcMem  = funct3;
         end
         OP_REG: begin
            if (funct7 == F7_BASE || funct7 == F7_ALT) begin
               dec.rs1_en   = 1'b1;
               dec.rs2_en   = 1'b1;
               dec.wbSel    = WB_ALU;
               dec.func3    = funct3;
               dec.func1    = instr_i[30];
               dec.regWrite = 1'b1;
            end else if (EN_MEXT && funct7 == F7_MEXT) begin
               dec.rs1_en   = 1'b1;
               dec.rs2_en   = 1'b1;
               dec.wbSel    = WB_ALU;
               dec.func3    = funct3;
               dec.is_mul   = 1'b1;
               dec.regWrite = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_IMM: begin
            // rs2 field is immediate bits here, so it never takes part in hazards
            dec.rs1_en   = 1'b1;
            dec.wbSel    = WB_ALU;
            dec.func3    = funct3;
            dec.func1    = (funct3 == F3_SR) ? instr_i[30] : 1'b0;
            dec.regWrite = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      if (!dec.regWrite) dec.rd = '0;
   end

   assign ctrl_o = dec;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode/control stage: main + one-entry skid buffer behind
// valid/ready, load-use bubble insertion, flush and a saturating stall counter.
module decode_ctrl_stage
   import ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter bit EN_MEXT = 1'b0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output ctrl_t            out_ctrl,
   output logic [XLEN-1:0]  out_pc,
   output logic [CNT_W-1:0] stall_cnt
);

   ctrl_t dec_ctrl;

   logic             main_valid_q, main_valid_d;
   ctrl_t            main_ctrl_q,  main_ctrl_d;
   logic [XLEN-1:0]  main_pc_q,    main_pc_d;
   logic             skid_valid_q, skid_valid_d;
   ctrl_t            skid_ctrl_q,  skid_ctrl_d;
   logic [XLEN-1:0]  skid_pc_q,    skid_pc_d;
   logic             in_ready_q,   in_ready_d;
   logic             ll_valid_q,   ll_valid_d;
   logic [4:0]       ll_rd_q,      ll_rd_d;
   logic [CNT_W-1:0] stall_q,      stall_d;

   logic in_fire, out_fire, hazard, out_valid_int;

   rv_ctrl_decode #(.EN_MEXT(EN_MEXT)) u_dec (
      .instr_i (in_instr),
      .ctrl_o  (dec_ctrl)
   );

   assign hazard = ll_valid_q & main_valid_q &
                   ((main_ctrl_q.rs1_en & (main_ctrl_q.rs1 == ll_rd_q)) |
                    (main_ctrl_q.rs2_en & (main_ctrl_q.rs2 == ll_rd_q)));
   assign out_valid_int = main_valid_q & ~hazard;
   assign in_fire       = in_valid & in_ready_q;
   assign out_fire      = out_valid_int & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_ctrl_d  = main_ctrl_q;
      main_pc_d    = main_pc_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_pc_d    = skid_pc_q;
      ll_valid_d   = ll_valid_q;
      ll_rd_d      = ll_rd_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         ll_valid_d   = 1'b0;
      end else begin
         // in_ready mirrors an empty skid, so a skid refill and an in-fire never coincide
         if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
               main_valid_d = 1'b1;
               main_ctrl_d  = skid_ctrl_q;
               main_pc_d    = skid_pc_q;
               skid_valid_d = 1'b0;
            end else begin
               main_valid_d = in_fire;
               if (in_fire) begin
                  main_ctrl_d = dec_ctrl;
                  main_pc_d   = in_pc;
               end
            end
         end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = dec_ctrl;
            skid_pc_d    = in_pc;
         end
         if (out_fire && main_ctrl_q.memRead && (main_ctrl_q.rd != 5'd0)) begin
            ll_valid_d = 1'b1;
            ll_rd_d    = main_ctrl_q.rd;
         end else if (out_ready) begin
            ll_valid_d = 1'b0;
         end
      end
      in_ready_d = ~skid_valid_d;
      stall_d    = (hazard && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_ctrl_q  <= '0;
         main_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= '0;
         skid_pc_q    <= '0;
         in_ready_q   <= 1'b0;
         ll_valid_q   <= 1'b0;
         ll_rd_q      <= '0;
         stall_q      <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_ctrl_q  <= main_ctrl_d;
         main_pc_q    <= main_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_pc_q    <= skid_pc_d;
         in_ready_q   <= in_ready_d;
         ll_valid_q   <= ll_valid_d;
         ll_rd_q      <= ll_rd_d;
         stall_q      <= stall_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_int;
   assign out_ctrl  = main_ctrl_q;
   assign out_pc    = main_pc_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: a decode vector table plus hand-written
// handshake, load-use, flush, saturation and mid-stream reset sequences.
module tb_decode_ctrl_stage;
   import ctrl_pkg::*;

   logic        clk;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_ready, out_valid, in_ready_m, out_valid_m;
   logic [31:0] out_pc, out_pc_m;
   ctrl_t       out_ctrl, out_ctrl_m;
   logic [15:0] stall_cnt;
   logic [3:0]  stall_cnt_m;

   int n_vec = 0;
   int n_bad = 0;

   decode_ctrl_stage u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_pc(out_pc), .stall_cnt(stall_cnt)
   );

   decode_ctrl_stage #(.XLEN(32), .EN_MEXT(1'b1), .CNT_W(4)) u_dut_m (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_m), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid_m), .out_ready(out_ready), .out_ctrl(out_ctrl_m),
      .out_pc(out_pc_m), .stall_cnt(stall_cnt_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        sel;
      logic [11:0] flags;
      logic [1:0]  wb;
      logic [2:0]  f3;
      logic [2:0]  fmem;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [11:0] flags_of(input ctrl_t c);
      return {c.rs1_en, c.rs2_en, c.brOrJmp, c.brUsed, c.br_useJalr, c.is_branch,
              c.func1, c.regWrite, c.memRead, c.memWrite, c.is_mul, c.illegal};
   endfunction

   task automatic add_vec(input logic [31:0] ins, input logic sel, input logic [11:0] fl,
                          input logic [1:0] wb, input logic [2:0] f3, input logic [2:0] fm,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      vec_t v;
      v.instr = ins; v.sel = sel; v.flags = fl; v.wb = wb; v.f3 = f3;
      v.fmem = fm; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      in_valid = v;
      in_instr = ins;
      in_pc    = pc;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ctrl_t c;
      logic  v;
      logic [31:0] p;

      // flags: rs1_en rs2_en brOrJmp brUsed br_useJalr is_branch func1 regWrite memRead memWrite is_mul illegal
      add_vec(enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd1,  7'h33), 1'b0, 12'hC10, 2'b01, 3'd0, 3'd0, 5'd1,  5'd2, 5'd3);
      add_vec(enc(7'h20, 5'd5, 5'd1, 3'd0, 5'd4,  7'h33), 1'b0, 12'hC30, 2'b01, 3'd0, 3'd0, 5'd4,  5'd1, 5'd5);
      add_vec(enc(7'h20, 5'd3, 5'd8, 3'd5, 5'd7,  7'h13), 1'b0, 12'h830, 2'b01, 3'd5, 3'd0, 5'd7,  5'd8, 5'd3);
      add_vec(enc(7'h20, 5'd0, 5'd8, 3'd0, 5'd9,  7'h13), 1'b0, 12'h810, 2'b01, 3'd0, 3'd0, 5'd9,  5'd8, 5'd0);
      add_vec(enc(7'h12, 5'd3, 5'd4, 3'd5, 5'd10, 7'h37), 1'b0, 12'h010, 2'b11, 3'd0, 3'd0, 5'd10, 5'd4, 5'd3);
      add_vec(enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd11, 7'h17), 1'b0, 12'h010, 2'b01, 3'd0, 3'd0, 5'd11, 5'd0, 5'd0);
      add_vec(enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1,  7'h6F), 1'b0, 12'h210, 2'b00, 3'd0, 3'd0, 5'd1,  5'd0, 5'd0);
      add_vec(enc(7'h00, 5'd0, 5'd3, 3'd0, 5'd2,  7'h67), 1'b0, 12'h990, 2'b00, 3'd0, 3'd0, 5'd2,  5'd3, 5'd0);
      add_vec(enc(7'h00, 5'd5, 5'd4, 3'd1, 5'd8,  7'h63), 1'b0, 12'hC40, 2'b00, 3'd1, 3'd0, 5'd0,  5'd4, 5'd5);
      add_vec(enc(7'h00, 5'd6, 5'd7, 3'd2, 5'd4,  7'h23), 1'b0, 12'hC04, 2'b00, 3'd0, 3'd2, 5'd0,  5'd7, 5'd6);
      add_vec(enc(7'h00, 5'd0, 5'd9, 3'd4, 5'd8,  7'h03), 1'b0, 12'h818, 2'b10, 3'd0, 3'd4, 5'd8,  5'd9, 5'd0);
      add_vec(enc(7'h00, 5'd1, 5'd2, 3'd0, 5'd3,  7'h7F), 1'b0, 12'h001, 2'b00, 3'd0, 3'd0, 5'd0,  5'd2, 5'd1);
      add_vec(enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd3,  7'h33), 1'b0, 12'h001, 2'b00, 3'd0, 3'd0, 5'd0,  5'd1, 5'd2);
      add_vec(enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd3,  7'h33), 1'b1, 12'hC12, 2'b01, 3'd0, 3'd0, 5'd3,  5'd1, 5'd2);
      add_vec(enc(7'h10, 5'd2, 5'd1, 3'd0, 5'd3,  7'h33), 1'b1, 12'h001, 2'b00, 3'd0, 3'd0, 5'd0,  5'd1, 5'd2);

      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drv(1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      chk("reset_state", 64'({in_ready, out_valid, out_ctrl}), 64'({1'b0, 1'b0, 35'h0}));
      chk("reset_pc_cnt", 64'({out_pc, stall_cnt}), 64'({32'h0, 16'h0}));
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));

      // decode table: one instruction at a time, out_ready held high
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drv(1'b1, vecs[i].instr, 32'h100 + 32'(4 * i));
         @(negedge clk);
         drv(1'b0, 32'h0, 32'h0);
         c = vecs[i].sel ? out_ctrl_m : out_ctrl;
         v = vecs[i].sel ? out_valid_m : out_valid;
         p = vecs[i].sel ? out_pc_m : out_pc;
         chk($sformatf("vec%0d", i),
             64'({v, flags_of(c), c.wbSel, c.func3, c.funcMem, c.rd, c.rs1, c.rs2, p[15:0]}),
             64'({1'b1, vecs[i].flags, vecs[i].wb, vecs[i].f3, vecs[i].fmem,
                  vecs[i].rd, vecs[i].rs1, vecs[i].rs2, 16'(32'h100 + 32'(4 * i))}));
      end

      // back-to-back ADD / SUB
      @(negedge clk);
      drv(1'b1, enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 32'h200);
      @(negedge clk);
      chk("t1_add", 64'({out_valid, out_ctrl.rd, out_ctrl.func1, out_pc[15:0]}), 64'({1'b1, 5'd1, 1'b0, 16'h200}));
      drv(1'b1, enc(7'h20, 5'd5, 5'd1, 3'd0, 5'd4, 7'h33), 32'h204);
      @(negedge clk);
      chk("t1_sub", 64'({out_valid, out_ctrl.rd, out_ctrl.func1, out_pc[15:0], stall_cnt}),
          64'({1'b1, 5'd4, 1'b1, 16'h204, 16'd0}));
      drv(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("t1_drain", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

      // load-use: LW x5 then ADD x6,x5,x7
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h300);
      @(negedge clk);
      chk("t2_lw", 64'({out_valid, out_ctrl.memRead, out_ctrl.rd}), 64'({1'b1, 1'b1, 5'd5}));
      drv(1'b1, enc(7'h00, 5'd7, 5'd5, 3'd0, 5'd6, 7'h33), 32'h304);
      @(negedge clk);
      chk("t2_bubble", 64'({out_valid, stall_cnt}), 64'({1'b0, 16'd0}));
      drv(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("t2_add", 64'({out_valid, out_ctrl.rd, out_pc[15:0], stall_cnt}), 64'({1'b1, 5'd6, 16'h304, 16'd1}));
      // same pattern with rd=x0: no bubble
      @(negedge clk);
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03), 32'h308);
      @(negedge clk);
      drv(1'b1, enc(7'h00, 5'd7, 5'd0, 3'd0, 5'd6, 7'h33), 32'h30C);
      @(negedge clk);
      chk("t2_x0_nobubble", 64'({out_valid, out_pc[15:0], stall_cnt}), 64'({1'b1, 16'h30C, 16'd1}));
      drv(1'b0, 32'h0, 32'h0);

      // backpressure: skid fills, order preserved on release
      @(negedge clk);
      out_ready = 1'b0;
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd10, 7'h13), 32'h400);
      @(negedge clk);
      chk("t3_a", 64'({out_valid, in_ready, out_ctrl.rd}), 64'({1'b1, 1'b1, 5'd10}));
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd11, 7'h13), 32'h404);
      @(negedge clk);
      chk("t3_skid_full", 64'({out_valid, in_ready, out_ctrl.rd, out_pc[15:0]}), 64'({1'b1, 1'b0, 5'd10, 16'h400}));
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd12, 7'h13), 32'h408);
      @(negedge clk);
      chk("t3_stable", 64'({out_valid, in_ready, out_ctrl, out_pc[15:0]}),
          64'({1'b1, 1'b0, 35'(enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd10, 7'h13) & 32'h0) | {1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd10, 5'd1, 5'd0}, 16'h400}));
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_b", 64'({out_valid, in_ready, out_ctrl.rd, out_pc[15:0]}), 64'({1'b1, 1'b1, 5'd11, 16'h404}));
      @(negedge clk);
      chk("t3_c", 64'({out_valid, out_ctrl.rd, out_pc[15:0]}), 64'({1'b1, 5'd12, 16'h408}));
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd13, 7'h13), 32'h40C);
      @(negedge clk);
      chk("t3_d", 64'({out_valid, out_ctrl.rd, out_pc[15:0]}), 64'({1'b1, 5'd13, 16'h40C}));
      drv(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("t3_drain", 64'({out_valid}), 64'({1'b0}));

      // flush together with a JAL in-fire and a held main
      out_ready = 1'b0;
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd14, 7'h13), 32'h500);
      @(negedge clk);
      chk("t4_held", 64'({out_valid, out_ctrl.rd}), 64'({1'b1, 5'd14}));
      drv(1'b1, enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'h6F), 32'h504);
      flush = 1'b1;
      @(negedge clk);
      chk("t4_flushed", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
      flush = 1'b0; out_ready = 1'b1;
      drv(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("t4_no_jal", 64'({out_valid, in_ready, stall_cnt}), 64'({1'b0, 1'b1, 16'd1}));

      // persistent hazard under backpressure; narrow counter saturates
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h600);
      @(negedge clk);
      drv(1'b1, enc(7'h00, 5'd7, 5'd5, 3'd0, 5'd6, 7'h33), 32'h604);
      @(negedge clk);
      drv(1'b0, 32'h0, 32'h0);
      out_ready = 1'b0;
      repeat (20) @(negedge clk);
      chk("t7_saturate", 64'({out_valid, stall_cnt, stall_cnt_m}), 64'({1'b0, 16'd21, 4'd15}));
      out_ready = 1'b1;
      @(negedge clk);
      chk("t7_release", 64'({out_valid, out_ctrl.rd, stall_cnt, stall_cnt_m}), 64'({1'b1, 5'd6, 16'd22, 4'd15}));

      // asynchronous reset with the skid full
      @(negedge clk);
      out_ready = 1'b0;
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd10, 7'h13), 32'h700);
      @(negedge clk);
      drv(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd11, 7'h13), 32'h704);
      @(negedge clk);
      chk("t6_full", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
      #2 rst_n = 1'b0;
      drv(1'b0, 32'h0, 32'h0);
      #1;
      chk("t6_async_ctrl", 64'({in_ready, out_valid, out_ctrl}), 64'({1'b0, 1'b0, 35'h0}));
      chk("t6_async_cnt", 64'({out_pc, stall_cnt, stall_cnt_m}), 64'({32'h0, 16'd0, 4'd0}));
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("t6_resume_idle", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
      drv(1'b1, enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 32'h800);
      @(negedge clk);
      chk("t6_resume_add", 64'({out_valid, out_ctrl.rd, out_pc[15:0]}), 64'({1'b1, 5'd1, 16'h800}));
      drv(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("t6_no_stale", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
